pc_fetch_sequencer: RTL

Program-counter sequencer that owns the PC register and drives instruction fetch. It generates the select and the two candidate addresses (PC+1, branch target) for the external 2:1 next-PC mux. It registers the mux result back as the new PC and runs a request/acknowledge handshake with instruction memory. Branch redirects insert a one-cycle flush bubble.

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/ret_addr_stack.sv | 50 +++++
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared constants and encodings for the PC fetch sequencer.
package pc_fetch_pkg;

  localparam int unsigned     ADDR_W   = 8;
  localparam logic [7:0]      RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    BRANCH,
    CALL,
    RET
  } redir_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: push when full overwrites the oldest entry,
// pop when empty reports RESET_PC and leaves the stack empty.
module ret_addr_stack #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  sp;
  logic [IDX_W-1:0]  sp_inc;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W:0]    count;

  // sp is the next write slot; the top entry sits just below it, modulo DEPTH
  always_comb begin
    sp_inc  = (sp == IDX_W'(DEPTH - 1)) ? '0 : sp + 1'b1;
    top_idx = (sp == '0) ? IDX_W'(DEPTH - 1) : sp - 1'b1;
    top     = (count == '0) ? RESET_PC : mem[top_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp_inc;
      if (count != (IDX_W + 1)'(DEPTH))
        count <= count + 1'b1;
    end else if (pop && count != '0) begin
      sp    <= top_idx;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[sp] <= push_addr;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, next-PC mux control and instruction-fetch handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_fetch_sequencer #(
  parameter int unsigned       ADDR_W    = pc_fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = pc_fetch_pkg::RESET_PC,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] next_pc_in,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] target_out,
  output logic              pcsrc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              flush
);

  import pc_fetch_pkg::*;

  state_t            state;
  redir_t            src;
  logic              redirect;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] ras_top;

  always_comb begin
    src = NONE;
`ifdef PC_RAS_EN
    if (ret)
      src = RET;
    else if (call)
      src = CALL;
    else if (branch_taken)
      src = BRANCH;
`else
    if (call)
      src = CALL;
    else if (branch_taken)
      src = BRANCH;
`endif
  end

`ifdef PC_RAS_EN
  // call+ret together leaves the stack untouched, so neither push nor pop fires
  ret_addr_stack #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (RAS_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (call & ~ret),
    .pop       (ret & ~call),
    .push_addr (pc_plus1),
    .top       (ras_top)
  );
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ret;
  assign unused_ret = ret;
  assign ras_top    = RESET_PC;
`endif

  assign redirect  = (src != NONE);
  assign pcsrc     = redirect & rst;
  assign pc_plus1  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign imem_addr = pc;

  always_comb begin
    target_out = target_q;
    if (src == RET)
      target_out = ras_top;
    else if (redirect)
      target_out = branch_target;
  end

  // imem_req is registered alongside state and is high exactly in FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      target_q    <= '0;
      imem_req    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      flush       <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      if (redirect) begin
        pc       <= next_pc_in;
        target_q <= target_out;
        flush    <= 1'b1;
        state    <= FLUSH;
        imem_req <= 1'b0;
      end else begin
        case (state)
          IDLE, FLUSH: begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
          FETCH: begin
            if (!stall && imem_ack) begin
              pc          <= next_pc_in;
              fetch_valid <= 1'b1;
              fetch_pc    <= pc;
            end
          end
          default: begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
